// File: rtl/sdram_mport_arbiter.sv
// Round-robin arbiter placing NCH write and NCH read FIFO channels onto one SDRAM
// controller port, with per-channel wrapping burst addresses and FIFO strobe steering.
module sdram_mport_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 23,
  parameter int FW  = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [NCH*FW-1:0] wr_fifo_num,
  input  logic [NCH*FW-1:0] rd_fifo_num,
  input  logic [NCH-1:0]    read_valid,
  input  logic [NCH*AW-1:0] sdram_wr_b_addr,
  input  logic [NCH*AW-1:0] sdram_wr_e_addr,
  input  logic [NCH*AW-1:0] sdram_rd_b_addr,
  input  logic [NCH*AW-1:0] sdram_rd_e_addr,
  input  logic [7:0]        wr_burst_len,
  input  logic [7:0]        rd_burst_len,
  output logic              sdram_wr_req,
  output logic [AW-1:0]     sdram_wr_addr,
  input  logic              sdram_wr_ack,
  input  logic              sdram_wr_end,
  output logic              sdram_rd_req,
  output logic [AW-1:0]     sdram_rd_addr,
  input  logic              sdram_rd_ack,
  input  logic              sdram_rd_end,
  output logic [NCH-1:0]    wr_grant,
  output logic [NCH-1:0]    rd_grant,
  output logic [NCH-1:0]    wr_fifo_rd_en,
  output logic [NCH-1:0]    rd_fifo_wr_en
);

  localparam int NR  = 2 * NCH;
  localparam int PW  = $clog2(NR);
  localparam int AW1 = AW + 1;

  typedef enum logic [1:0] {IDLE, ARB, WR, RD} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  rr_ptr, win_idx, pick_idx;
  logic [AW-1:0]  offset [NR];
  logic [NR-1:0]  elig;
  logic           pick_ok, pick_wr;
  int             pick_ch;
  logic [NCH-1:0] pick_onehot;
  logic [AW-1:0]  pick_addr;
  logic           win_wr, end_hit, wrap;
  int             win_ch;
  logic [AW-1:0]  win_b, win_e;
  logic [7:0]     win_len;
  logic [AW:0]    nxt_n, nxt_last;

  // Requester i is write channel i, requester NCH+i is read channel i.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i]       = int'(wr_fifo_num[i*FW +: FW]) >= int'(wr_burst_len);
      elig[NCH + i] = read_valid[i] && (int'(rd_fifo_num[i*FW +: FW]) < int'(rd_burst_len));
    end
  end

  // Scan downward so the eligible requester closest to rr_ptr is the last one written.
  always_comb begin
    int j;
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NR;
      if (elig[j]) begin
        pick_ok  = 1'b1;
        pick_idx = PW'(j);
      end
    end
  end

  always_comb begin
    pick_wr     = int'(pick_idx) < NCH;
    pick_ch     = pick_wr ? int'(pick_idx) : int'(pick_idx) - NCH;
    pick_onehot = '0;
    pick_onehot[pick_ch] = 1'b1;
    pick_addr   = (pick_wr ? sdram_wr_b_addr[pick_ch*AW +: AW]
                           : sdram_rd_b_addr[pick_ch*AW +: AW]) + offset[pick_idx];
  end

  // Wrap check for the channel that owns the finishing burst, in AW+1 bits.
  always_comb begin
    win_wr   = state == WR;
    win_ch   = win_wr ? int'(win_idx) : int'(win_idx) - NCH;
    win_b    = win_wr ? sdram_wr_b_addr[win_ch*AW +: AW] : sdram_rd_b_addr[win_ch*AW +: AW];
    win_e    = win_wr ? sdram_wr_e_addr[win_ch*AW +: AW] : sdram_rd_e_addr[win_ch*AW +: AW];
    win_len  = win_wr ? wr_burst_len : rd_burst_len;
    nxt_n    = {1'b0, win_b} + {1'b0, offset[win_idx]} + AW1'(win_len);
    nxt_last = nxt_n + AW1'(win_len) - AW1'(1);
    wrap     = nxt_last > {1'b0, win_e};
    end_hit  = (state == WR && sdram_wr_end) || (state == RD && sdram_rd_end);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!init_end) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ARB;
        ARB:     if (pick_ok) state_nxt = pick_wr ? WR : RD;
        WR:      if (sdram_wr_end) state_nxt = ARB;
        RD:      if (sdram_rd_end) state_nxt = ARB;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered request/address/grant outputs plus round-robin and offset bookkeeping.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_ptr        <= '0;
      win_idx       <= '0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      wr_grant      <= '0;
      rd_grant      <= '0;
      for (int i = 0; i < NR; i++) offset[i] <= '0;
    end else begin
      if (end_hit) begin
        offset[win_idx] <= wrap ? '0 : offset[win_idx] + AW'(win_len);
        rr_ptr          <= (int'(win_idx) == NR - 1) ? '0 : win_idx + 1'b1;
      end
      if (!init_end || end_hit) begin
        sdram_wr_req <= 1'b0;
        sdram_rd_req <= 1'b0;
        wr_grant     <= '0;
        rd_grant     <= '0;
      end else if (state == ARB && pick_ok) begin
        win_idx <= pick_idx;
        if (pick_wr) begin
          sdram_wr_req  <= 1'b1;
          sdram_wr_addr <= pick_addr;
          wr_grant      <= pick_onehot;
        end else begin
          sdram_rd_req  <= 1'b1;
          sdram_rd_addr <= pick_addr;
          rd_grant      <= pick_onehot;
        end
      end
    end
  end

  assign wr_fifo_rd_en = wr_grant & {NCH{sdram_wr_ack}};
  assign rd_fifo_wr_en = rd_grant & {NCH{sdram_rd_ack}};

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// Directed bench for sdram_mport_arbiter: a table of back-to-back bursts with
// hand-computed owners/addresses, then reset-mid-burst and init_end-drop sequences.
module tb_sdram_mport_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 23;
  localparam int FW  = 10;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              init_end = 1'b0;
  logic [NCH*FW-1:0] wr_fifo_num = '0;
  logic [NCH*FW-1:0] rd_fifo_num = '0;
  logic [NCH-1:0]    read_valid = '0;
  logic [NCH*AW-1:0] sdram_wr_b_addr, sdram_wr_e_addr, sdram_rd_b_addr, sdram_rd_e_addr;
  logic [7:0]        wr_burst_len = 8'd10;
  logic [7:0]        rd_burst_len = 8'd10;
  logic              sdram_wr_req, sdram_rd_req;
  logic [AW-1:0]     sdram_wr_addr, sdram_rd_addr;
  logic              sdram_wr_ack = 1'b0, sdram_wr_end = 1'b0;
  logic              sdram_rd_ack = 1'b0, sdram_rd_end = 1'b0;
  logic [NCH-1:0]    wr_grant, rd_grant, wr_fifo_rd_en, rd_fifo_wr_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_mport_arbiter #(.NCH(NCH), .AW(AW), .FW(FW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num), .read_valid(read_valid),
    .sdram_wr_b_addr(sdram_wr_b_addr), .sdram_wr_e_addr(sdram_wr_e_addr),
    .sdram_rd_b_addr(sdram_rd_b_addr), .sdram_rd_e_addr(sdram_rd_e_addr),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_ack(sdram_wr_ack), .sdram_wr_end(sdram_wr_end),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_end(sdram_rd_end),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_fifo_rd_en(wr_fifo_rd_en), .rd_fifo_wr_en(rd_fifo_wr_en)
  );

  typedef struct {
    logic [FW-1:0] wn0, wn1, rn0, rn1;
    logic [1:0]    rv;
    bit            is_wr;
    logic [1:0]    grant;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    wr_fifo_num = {v.wn1, v.wn0};
    rd_fifo_num = {v.rn1, v.rn0};
    read_valid  = v.rv;
  endtask

  task automatic wait_req(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 40) begin
      @(posedge sys_clk); #1;
      lat++;
      if (sdram_wr_req || sdram_rd_req) ok = 1'b1;
    end
    check("req_timeout", {31'd0, ok}, 32'd1);
    check("req_exclusive", {30'd0, sdram_wr_req, sdram_rd_req} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_owner(input bit exp_wr, input logic [1:0] exp_g, input logic [AW-1:0] exp_addr);
    check("req_kind", {30'd0, sdram_wr_req, sdram_rd_req}, exp_wr ? 32'd2 : 32'd1);
    check("grant", {30'd0, exp_wr ? wr_grant : rd_grant}, {30'd0, exp_g});
    check("other_grant", {30'd0, exp_wr ? rd_grant : wr_grant}, 32'd0);
    check("addr", {9'd0, exp_wr ? sdram_wr_addr : sdram_rd_addr}, {9'd0, exp_addr});
  endtask

  // Waits for a request, checks owner, streams len acks, then pulses end.
  task automatic run_burst(input bit exp_wr, input logic [1:0] exp_g,
                           input logic [AW-1:0] exp_addr, input int exp_lat);
    int lat, strobes;
    bit ok, held;
    wait_req(lat, ok);
    if (!ok) return;
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check_owner(exp_wr, exp_g, exp_addr);
    strobes = 0;
    held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (exp_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
      @(negedge sys_clk);
      if ((exp_wr ? wr_fifo_rd_en : rd_fifo_wr_en) == exp_g) strobes++;
      if (!(exp_wr ? sdram_wr_req : sdram_rd_req)) held = 1'b0;
      if ((exp_wr ? sdram_wr_addr : sdram_rd_addr) != exp_addr) held = 1'b0;
      @(posedge sys_clk); #1;
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    check("strobe_count", strobes, 10);
    check("held_stable", {31'd0, held}, 32'd1);
    if (exp_wr) sdram_wr_end = 1'b1; else sdram_rd_end = 1'b1;
    @(posedge sys_clk); #1;
    sdram_wr_end = 1'b0;
    sdram_rd_end = 1'b0;
    check("clear_after_end", {26'd0, sdram_wr_req, sdram_rd_req, wr_grant, rd_grant}, 32'd0);
  endtask

  initial begin
    int lat;
    bit ok;
    vec_t v;
    sdram_wr_b_addr = {23'd1000, 23'd0};
    sdram_wr_e_addr = {23'd1025, 23'd99};
    sdram_rd_b_addr = {23'd3000, 23'd2000};
    sdram_rd_e_addr = {23'd3099, 23'd2099};

    //          wn0  wn1  rn0  rn1  rv     wr    grant  addr
    vecs[0]  = '{10'd20, 10'd0,  10'd10, 10'd10, 2'b00, 1'b1, 2'b01, 23'd0};
    vecs[1]  = '{10'd20, 10'd0,  10'd10, 10'd10, 2'b00, 1'b1, 2'b01, 23'd10};
    vecs[2]  = '{10'd9,  10'd10, 10'd10, 10'd10, 2'b00, 1'b1, 2'b10, 23'd1000};
    vecs[3]  = '{10'd9,  10'd10, 10'd10, 10'd10, 2'b00, 1'b1, 2'b10, 23'd1010};
    vecs[4]  = '{10'd9,  10'd10, 10'd10, 10'd10, 2'b00, 1'b1, 2'b10, 23'd1000};
    vecs[5]  = '{10'd20, 10'd20, 10'd0,  10'd0,  2'b11, 1'b0, 2'b01, 23'd2000};
    vecs[6]  = '{10'd20, 10'd20, 10'd0,  10'd0,  2'b11, 1'b0, 2'b10, 23'd3000};
    vecs[7]  = '{10'd20, 10'd20, 10'd0,  10'd0,  2'b11, 1'b1, 2'b01, 23'd20};
    vecs[8]  = '{10'd20, 10'd20, 10'd0,  10'd0,  2'b11, 1'b1, 2'b10, 23'd1010};
    vecs[9]  = '{10'd20, 10'd20, 10'd0,  10'd0,  2'b11, 1'b0, 2'b01, 23'd2010};
    vecs[10] = '{10'd0,  10'd0,  10'd0,  10'd0,  2'b01, 1'b0, 2'b01, 23'd2020};
    vecs[11] = '{10'd0,  10'd0,  10'd0,  10'd0,  2'b01, 1'b0, 2'b01, 23'd2030};
    vecs[12] = '{10'd0,  10'd0,  10'd10, 10'd5,  2'b11, 1'b0, 2'b10, 23'd3010};

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_reqs", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    check("reset_grants", {28'd0, wr_grant, rd_grant}, 32'd0);
    check("reset_addrs", {9'd0, sdram_wr_addr | sdram_rd_addr}, 32'd0);
    sys_rst  = 1'b0;
    init_end = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      run_burst(vecs[i].is_wr, vecs[i].grant, vecs[i].addr, (i == 0) ? -1 : 1);
    end

    // Asynchronous reset in the middle of a write burst
    v = '{10'd20, 10'd0, 10'd10, 10'd10, 2'b00, 1'b1, 2'b01, 23'd30};
    apply(v);
    wait_req(lat, ok);
    check_owner(1'b1, 2'b01, 23'd30);
    sdram_wr_ack = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check("async_rst_reqs", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    check("async_rst_grant", {28'd0, wr_grant, rd_grant}, 32'd0);
    check("async_rst_strobe", {28'd0, wr_fifo_rd_en, rd_fifo_wr_en}, 32'd0);
    check("async_rst_addr", {9'd0, sdram_wr_addr}, 32'd0);
    sdram_wr_ack = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    run_burst(1'b1, 2'b01, 23'd0, 2);

    // init_end drop during a read burst, stray ack/end while idle
    v = '{10'd0, 10'd0, 10'd0, 10'd10, 2'b01, 1'b0, 2'b01, 23'd2000};
    apply(v);
    wait_req(lat, ok);
    check_owner(1'b0, 2'b01, 23'd2000);
    sdram_rd_ack = 1'b1;
    @(posedge sys_clk); #1;
    init_end = 1'b0;
    @(posedge sys_clk); #1;
    check("init_drop_reqs", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    check("init_drop_grant", {28'd0, wr_grant, rd_grant}, 32'd0);
    check("stray_ack_strobe", {28'd0, wr_fifo_rd_en, rd_fifo_wr_en}, 32'd0);
    sdram_rd_ack = 1'b0;
    sdram_wr_end = 1'b1;
    sdram_rd_end = 1'b1;
    @(posedge sys_clk); #1;
    sdram_wr_end = 1'b0;
    sdram_rd_end = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("idle_no_req", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
    v = '{10'd20, 10'd20, 10'd0, 10'd0, 2'b11, 1'b1, 2'b10, 23'd1000};
    apply(v);
    init_end = 1'b1;
    run_burst(1'b1, 2'b10, 23'd1000, 2);
    run_burst(1'b0, 2'b01, 23'd2000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_mport_arbiter.md
# sdram_mport_arbiter

Parametrised multi-channel successor to the single write/read FIFO controller that sits in front of `sdram_pro_sdram_ctrl`. It serves NCH independent write channels and NCH independent read channels, each backed by its own external FIFO and its own SDRAM address window. It arbitrates them round-robin onto the controller's single wr/rd request/ack port, generates per-channel wrapping burst addresses, and steers FIFO read/write strobes to the channel that owns the current burst.

## Interface
Parameters:
- NCH, 2 — number of write channels, and also number of read channels (1..8)
- AW, 23 — SDRAM word-address width
- FW, 10 — per-channel FIFO fill-count width

Ports (clock and reset first; per-channel buses are flattened, channel i at slice [i*W +: W]):
- sys_clk  in  1  — SDRAM controller clock; the only clock
- sys_rst  in  1  — reset, asynchronous, active-high
- init_end  in  1  — SDRAM initialisation complete
- wr_fifo_num  in  NCH*FW  — fill level of each write FIFO
- rd_fifo_num  in  NCH*FW  — fill level of each read FIFO
- read_valid  in  NCH  — per-read-channel enable
- sdram_wr_b_addr / sdram_wr_e_addr  in  NCH*AW  — write window first/last address per channel
- sdram_rd_b_addr / sdram_rd_e_addr  in  NCH*AW  — read window first/last address per channel
- wr_burst_len / rd_burst_len  in  8  — burst length, shared by all channels, 1..255
- sdram_wr_req  out  1  — write request to controller
- sdram_wr_addr  out  AW  — write burst start address
- sdram_wr_ack  in  1  — controller consumes one write word per cycle high
- sdram_wr_end  in  1  — one-cycle pulse: write burst finished
- sdram_rd_req  out  1  — read request to controller
- sdram_rd_addr  out  AW  — read burst start address
- sdram_rd_ack  in  1  — one read word valid per cycle high
- sdram_rd_end  in  1  — one-cycle pulse: read burst finished
- wr_grant  out  NCH  — one-hot owner of the current write burst
- rd_grant  out  NCH  — one-hot owner of the current read burst
- wr_fifo_rd_en  out  NCH  — wr_grant & {NCH{sdram_wr_ack}} (combinational)
- rd_fifo_wr_en  out  NCH  — rd_grant & {NCH{sdram_rd_ack}} (combinational)

## Operation
- 2*NCH requesters: index i = write channel i, index NCH+i = read channel i.
- Eligibility:
  - Write i is eligible when wr_fifo_num[i] >= wr_burst_len.
  - Read i is eligible when read_valid[i] is high and rd_fifo_num[i] < rd_burst_len.
- FSM states:
  - IDLE: entered from reset; leaves to ARB once init_end is high.
  - ARB: chooses the first eligible requester at or after rr_ptr, scanning cyclically. The winner's grant bit and the matching req/addr register on the exit edge, and the FSM goes to WR or RD. With no eligible requester it stays in ARB.
  - WR: holds sdram_wr_req, sdram_wr_addr and wr_grant stable until sdram_wr_end, then goes to ARB.
  - RD: holds sdram_rd_req, sdram_rd_addr and rd_grant stable until sdram_rd_end, then goes to ARB.
- On the end pulse: req and grant clear, and rr_ptr becomes winner+1 modulo 2*NCH.
- Addressing uses 2*NCH offset registers of AW bits, reset to 0. The burst address is b_addr + offset, computed in AW bits.
- Wrap rule, evaluated on the end pulse using AW+1-bit arithmetic:
  - n = b_addr + offset + len.
  - If n + len - 1 > e_addr, offset ← 0; otherwise offset ← offset + len.
- If init_end falls in any state, the FSM returns to IDLE, clears req and grant, and keeps rr_ptr and all offsets.
- At most one of sdram_wr_req / sdram_rd_req is high in any cycle. Grants are zero or one-hot.
- ack or end pulses arriving outside WR/RD are ignored.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, rr_ptr to 0, and all offsets to 0.
- Arbitration latency: req rises one cycle after the FSM is in ARB with an eligible requester.
- Back-to-back bursts have a minimum gap of 1 cycle: the end cycle, then one ARB cycle, then req high.
- FIFO strobes follow sdram_wr_ack / sdram_rd_ack with zero latency.
- Eligibility inputs are sampled only in ARB. Changes during a burst have no effect on that burst.
- Simultaneous end and init_end low: the offset update still happens, then the FSM goes to IDLE.

## Test plan
- Single write channel: NCH=2, wr_burst_len=10, ch0 window 0..99, wr_fifo_num[0]=20 → wr_req with addr 0, wr_grant=01, and 10 wr_fifo_rd_en[0] strobes. The next burst has addr 10.
- Write wrap: ch0 window 0..25, len 10 → addresses 0, 10, then 0 again, because 20+9 > 25.
- Round-robin fairness: all 4 requesters eligible continuously → bursts are granted in order W0, W1, R0, R1, W0, …
- Read gating: read_valid[1]=0 with rd_fifo_num[1]=0 → R1 is never granted. Setting read_valid[1]=1 → R1 is granted in the next ARB cycle, with rd_fifo_wr_en[1] pulsing on each rd_ack.
- Reset during WR: sys_rst asserted mid-burst → all outputs 0 asynchronously. After release and with init_end high, W0 restarts at b_addr.
- init_end drop during RD → req and grant clear. When init_end rises again, arbitration resumes from the saved rr_ptr and offsets.
